// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU codes and phase states.
package instruction_sequencer_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_OUT   = 2'd2,
    S_IN    = 2'd3
  } state_t;

  localparam logic [3:0] OP_JC    = 4'h0;
  localparam logic [3:0] OP_JNC   = 4'h1;
  localparam logic [3:0] OP_CMPI  = 4'h2;
  localparam logic [3:0] OP_CMPM  = 4'h3;
  localparam logic [3:0] OP_LIT   = 4'h4;
  localparam logic [3:0] OP_IN    = 4'h5;
  localparam logic [3:0] OP_LD    = 4'h6;
  localparam logic [3:0] OP_ST    = 4'h7;
  localparam logic [3:0] OP_JZ    = 4'h8;
  localparam logic [3:0] OP_JNZ   = 4'h9;
  localparam logic [3:0] OP_ADDI  = 4'hA;
  localparam logic [3:0] OP_ADDM  = 4'hB;
  localparam logic [3:0] OP_JMP   = 4'hC;
  localparam logic [3:0] OP_OUT   = 4'hD;
  localparam logic [3:0] OP_NANDI = 4'hE;
  localparam logic [3:0] OP_NANDM = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_ADD  = 2'b10;
  localparam logic [1:0] ALU_NAND = 2'b11;

endpackage

// File: rtl/instruction_sequencer_opcode_decode.sv
// Pure combinational opcode decode; the top gates these with the phase state.
module instruction_sequencer_opcode_decode
  import instruction_sequencer_pkg::*;
(
  input  logic [3:0] instr,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       two_byte,
  output logic       is_jump,
  output logic       taken,
  output logic [1:0] alu_op,
  output logic       src_ram,
  output logic       acc_we,
  output logic       flags_we,
  output logic       ram_oe,
  output logic       ram_we,
  output logic       is_in,
  output logic       is_out
);

  // Map each opcode to its strobes and jump condition.
  always_comb begin
    two_byte = 1'b0;
    is_jump  = 1'b0;
    taken    = 1'b0;
    alu_op   = ALU_PASS;
    src_ram  = 1'b0;
    acc_we   = 1'b0;
    flags_we = 1'b0;
    ram_oe   = 1'b0;
    ram_we   = 1'b0;
    is_in    = 1'b0;
    is_out   = 1'b0;
    case (instr)
      OP_JC:    begin two_byte = 1'b1; is_jump = 1'b1; taken = c_flag;  end
      OP_JNC:   begin two_byte = 1'b1; is_jump = 1'b1; taken = !c_flag; end
      OP_JZ:    begin two_byte = 1'b1; is_jump = 1'b1; taken = z_flag;  end
      OP_JNZ:   begin two_byte = 1'b1; is_jump = 1'b1; taken = !z_flag; end
      OP_JMP:   begin two_byte = 1'b1; is_jump = 1'b1; taken = 1'b1;    end
      OP_LD:    begin two_byte = 1'b1; ram_oe = 1'b1; src_ram = 1'b1; acc_we = 1'b1; end
      OP_ST:    begin two_byte = 1'b1; ram_we = 1'b1; end
      OP_CMPI:  begin alu_op = ALU_SUB; flags_we = 1'b1; end
      OP_CMPM:  begin alu_op = ALU_SUB; flags_we = 1'b1; src_ram = 1'b1; end
      OP_ADDI:  begin alu_op = ALU_ADD; acc_we = 1'b1; flags_we = 1'b1; end
      OP_ADDM:  begin alu_op = ALU_ADD; acc_we = 1'b1; flags_we = 1'b1; src_ram = 1'b1; end
      OP_NANDI: begin alu_op = ALU_NAND; acc_we = 1'b1; flags_we = 1'b1; end
      OP_NANDM: begin alu_op = ALU_NAND; acc_we = 1'b1; flags_we = 1'b1; src_ram = 1'b1; end
      OP_LIT:   begin alu_op = ALU_PASS; acc_we = 1'b1; end
      OP_IN:    is_in  = 1'b1;
      OP_OUT:   is_out = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/instruction_sequencer.sv
// FETCH/EXEC phase machine with IN/OUT handshake states driving the fetch path and datapath strobes.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        instr,
  input  logic [3:0]        oprnd,
  input  logic [7:0]        prog_b,
  input  logic              c_flag,
  input  logic              z_flag,
  output logic              eneable_fetch,
  output logic              eneable_counter,
  output logic              load,
  output logic [ADDR_W-1:0] valor,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [1:0]        alu_op,
  output logic              src_ram,
  output logic              acc_we,
  output logic              flags_we,
  output logic              acc_oe,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              in_ready,
  input  logic              in_valid
);

  state_t state_q, state_d;

  logic       dec_two_byte, dec_is_jump, dec_taken;
  logic [1:0] dec_alu_op;
  logic       dec_src_ram, dec_acc_we, dec_flags_we;
  logic       dec_ram_oe, dec_ram_we, dec_is_in, dec_is_out;

  instruction_sequencer_opcode_decode u_decode (
    .instr    (instr),
    .c_flag   (c_flag),
    .z_flag   (z_flag),
    .two_byte (dec_two_byte),
    .is_jump  (dec_is_jump),
    .taken    (dec_taken),
    .alu_op   (dec_alu_op),
    .src_ram  (dec_src_ram),
    .acc_we   (dec_acc_we),
    .flags_we (dec_flags_we),
    .ram_oe   (dec_ram_oe),
    .ram_we   (dec_ram_we),
    .is_in    (dec_is_in),
    .is_out   (dec_is_out)
  );

  // Next-state logic; IN/OUT hold until their handshake completes regardless of run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (run) state_d = S_EXEC;
      S_EXEC: begin
        if (dec_is_out)     state_d = S_OUT;
        else if (dec_is_in) state_d = S_IN;
        else                state_d = S_FETCH;
      end
      S_OUT:   if (out_ready) state_d = S_FETCH;
      S_IN:    if (in_valid)  state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Output decode from state and opcode; reset forces everything low asynchronously.
  always_comb begin
    eneable_fetch   = 1'b0;
    eneable_counter = 1'b0;
    load            = 1'b0;
    valor           = '0;
    mem_addr        = '0;
    ram_oe          = 1'b0;
    ram_we          = 1'b0;
    alu_op          = ALU_PASS;
    src_ram         = 1'b0;
    acc_we          = 1'b0;
    flags_we        = 1'b0;
    acc_oe          = 1'b0;
    out_valid       = 1'b0;
    in_ready        = 1'b0;
    if (!reset) begin
      valor    = {oprnd, prog_b};
      mem_addr = {oprnd, prog_b};
      case (state_q)
        S_FETCH: begin
          eneable_fetch   = run;
          eneable_counter = run;
        end
        S_EXEC: begin
          // A taken jump loads the PC; every other two-byte op skips its second byte.
          load            = dec_is_jump & dec_taken;
          eneable_counter = dec_two_byte & !(dec_is_jump & dec_taken);
          ram_oe          = dec_ram_oe;
          ram_we          = dec_ram_we;
          acc_oe          = dec_ram_we;
          alu_op          = dec_alu_op;
          src_ram         = dec_src_ram;
          acc_we          = dec_acc_we;
          flags_we        = dec_flags_we;
        end
        S_OUT: begin
          out_valid = 1'b1;
          acc_oe    = 1'b1;
        end
        S_IN: begin
          in_ready = 1'b1;
          acc_we   = in_valid;
          alu_op   = ALU_PASS;
          src_ram  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Phase state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: expected strobes queued per driven cycle, compared at negedge.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset, run;
  logic [3:0]  instr, oprnd;
  logic [7:0]  prog_b;
  logic        c_flag, z_flag, out_ready, in_valid;
  logic        eneable_fetch, eneable_counter, load;
  logic [11:0] valor, mem_addr;
  logic        ram_oe, ram_we;
  logic [1:0]  alu_op;
  logic        src_ram, acc_we, flags_we, acc_oe, out_valid, in_ready;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [12:0] ctl;
    logic [11:0] addr;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  instruction_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .oprnd(oprnd), .prog_b(prog_b),
    .c_flag(c_flag), .z_flag(z_flag), .eneable_fetch(eneable_fetch),
    .eneable_counter(eneable_counter), .load(load), .valor(valor), .mem_addr(mem_addr),
    .ram_oe(ram_oe), .ram_we(ram_we), .alu_op(alu_op), .src_ram(src_ram), .acc_we(acc_we),
    .flags_we(flags_we), .acc_oe(acc_oe), .out_valid(out_valid), .out_ready(out_ready),
    .in_ready(in_ready), .in_valid(in_valid)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control vector order: fetch, counter, load, ram_oe, ram_we, alu_op, src_ram, acc_we, flags_we, acc_oe, out_valid, in_ready
  function automatic logic [12:0] ctl(input logic ef, ec, ld, roe, rwe, input logic [1:0] alu,
                                      input logic src, awe, fwe, aoe, ov, ir);
    return {ef, ec, ld, roe, rwe, alu, src, awe, fwe, aoe, ov, ir};
  endfunction

  localparam logic [12:0] Z = 13'd0;

  // Drive one cycle's inputs just after the clock edge and queue the outputs the spec requires.
  task automatic step(input logic rst_v, run_v, input logic [3:0] ins, opr, input logic [7:0] pb,
                      input logic c, z, ordy, ival, input logic [12:0] exp_ctl);
    exp_t e;
    @(posedge clk); #1;
    reset = rst_v; run = run_v; instr = ins; oprnd = opr; prog_b = pb;
    c_flag = c; z_flag = z; out_ready = ordy; in_valid = ival;
    e.ctl  = exp_ctl;
    e.addr = rst_v ? 12'h000 : {opr, pb};
    sb_q.push_back(e);
  endtask

  task automatic fetch_cyc(input logic run_v);
    step(1'b0, run_v, instr, oprnd, prog_b, c_flag, z_flag, 1'b0, 1'b0,
         run_v ? ctl(1,1,0,0,0,2'b00,0,0,0,0,0,0) : Z);
  endtask

  // Compare DUT outputs against the oldest queued expectation, mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk_val("ctl", {19'd0, eneable_fetch, eneable_counter, load, ram_oe, ram_we, alu_op,
                      src_ram, acc_we, flags_we, acc_oe, out_valid, in_ready}, {19'd0, e.ctl});
      chk_val("valor", {20'd0, valor}, {20'd0, e.addr});
      chk_val("mem_addr", {20'd0, mem_addr}, {20'd0, e.addr});
      chk_val("load_ec_excl", {31'd0, load & eneable_counter}, 32'd0);
    end
  end

  initial begin
    reset = 1'b1; run = 1'b1; instr = 4'h0; oprnd = 4'h0; prog_b = 8'h00;
    c_flag = 1'b0; z_flag = 1'b0; out_ready = 1'b0; in_valid = 1'b0;

    // reset holds everything low even with run high
    step(1, 1, 4'h0, 4'h0, 8'h00, 0, 0, 0, 0, Z);
    // reach S_OUT, then reset mid-handshake
    fetch_cyc(1);
    step(0, 1, 4'hD, 4'h2, 8'h11, 0, 0, 0, 0, Z);
    step(0, 1, 4'hD, 4'h2, 8'h11, 0, 0, 0, 0, ctl(0,0,0,0,0,2'b00,0,0,0,1,1,0));
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_val("rst_acc_oe", {31'd0, acc_oe}, 32'd0);
    chk_val("rst_fetch", {31'd0, eneable_fetch}, 32'd0);
    fetch_cyc(1);
    // JMP
    step(0, 1, 4'hC, 4'h3, 8'h4A, 0, 0, 0, 0, ctl(0,0,1,0,0,2'b00,0,0,0,0,0,0));
    fetch_cyc(1);
    // JC not taken / taken
    step(0, 1, 4'h0, 4'h1, 8'h55, 0, 0, 0, 0, ctl(0,1,0,0,0,2'b00,0,0,0,0,0,0));
    fetch_cyc(1);
    step(0, 1, 4'h0, 4'h1, 8'h55, 1, 0, 0, 0, ctl(0,0,1,0,0,2'b00,0,0,0,0,0,0));
    fetch_cyc(1);
    // JNZ with z set: not taken; JZ with z set: taken
    step(0, 1, 4'h9, 4'h7, 8'hE0, 0, 1, 0, 0, ctl(0,1,0,0,0,2'b00,0,0,0,0,0,0));
    fetch_cyc(1);
    step(0, 1, 4'h8, 4'h7, 8'hE0, 0, 1, 0, 0, ctl(0,0,1,0,0,2'b00,0,0,0,0,0,0));
    fetch_cyc(1);
    // ADDI: single-cycle strobe then back to fetch
    step(0, 1, 4'hA, 4'h5, 8'h00, 0, 0, 0, 0, ctl(0,0,0,0,0,2'b10,0,1,1,0,0,0));
    fetch_cyc(1);
    // OUT waits three cycles for out_ready, run ignored while waiting
    step(0, 1, 4'hD, 4'h0, 8'h08, 0, 0, 0, 0, Z);
    for (int i = 0; i < 3; i++)
      step(0, 0, 4'hD, 4'h0, 8'h08, 0, 0, 0, 0, ctl(0,0,0,0,0,2'b00,0,0,0,1,1,0));
    step(0, 0, 4'hD, 4'h0, 8'h08, 0, 0, 1, 0, ctl(0,0,0,0,0,2'b00,0,0,0,1,1,0));
    fetch_cyc(1);
    // IN waits one cycle for in_valid
    step(0, 1, 4'h5, 4'h0, 8'h09, 0, 0, 0, 0, Z);
    step(0, 1, 4'h5, 4'h0, 8'h09, 0, 0, 0, 0, ctl(0,0,0,0,0,2'b00,0,0,0,0,0,1));
    step(0, 1, 4'h5, 4'h0, 8'h09, 0, 0, 0, 1, ctl(0,0,0,0,0,2'b00,0,1,0,0,0,1));
    fetch_cyc(1);
    // LD, CMPM, NANDI, LIT
    step(0, 1, 4'h6, 4'h2, 8'h34, 0, 0, 0, 0, ctl(0,1,0,1,0,2'b00,1,1,0,0,0,0));
    fetch_cyc(1);
    step(0, 1, 4'h3, 4'h4, 8'h00, 0, 0, 0, 0, ctl(0,0,0,0,0,2'b01,1,0,1,0,0,0));
    fetch_cyc(1);
    step(0, 1, 4'hE, 4'hB, 8'h00, 0, 0, 0, 0, ctl(0,0,0,0,0,2'b11,0,1,1,0,0,0));
    fetch_cyc(1);
    step(0, 1, 4'h4, 4'h6, 8'h00, 0, 0, 0, 0, ctl(0,0,0,0,0,2'b00,0,1,0,0,0,0));
    // single-step hold, then ST
    for (int i = 0; i < 5; i++) fetch_cyc(0);
    fetch_cyc(1);
    step(0, 1, 4'h7, 4'h1, 8'h20, 0, 0, 0, 0, ctl(0,1,0,0,1,2'b00,0,0,0,1,0,0));
    fetch_cyc(1);

    @(negedge clk); #1;
    chk_val("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
